sample_frame_tx: RTL and testbench

Parametrised sample-to-UART packetiser. It sits between a multi-channel sensor front end (accelerometer driver or similar) and the UART transmitter. Each sample strobe is captured into a frame FIFO, then sent as a framed byte stream: sync byte, sequence number, channel data, and an optional checksum. Drops caused by back-pressure are visible to the host both as sequence gaps and as a sticky flag.

---
 rtl/sample_frame_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/sample_frame_tx.sv | 189 ++++++++++++++++++
 tb/tb_sample_frame_tx.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_frame_pkg.sv
`default_nettype none
//==============================================================================
// Module   : sample_frame_pkg
// Brief    : Shared state encoding, frame-length helper and default sync byte
//            for the sample-to-UART packetiser.
// Revision : 1.0 - initial release
//==============================================================================
package sample_frame_pkg;

    localparam int         C_STATE_W      = 3;
    localparam logic [7:0] C_SYNC_DEFAULT = 8'hA5;

    typedef enum logic [C_STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_SEQ  = 3'd2,
        ST_DATA = 3'd3,
        ST_CHK  = 3'd4
    } state_e;

    // Total bytes on the wire per frame: sync, seq, payload, optional checksum.
    function automatic int nb(input int nch, input int sw, input int chk);
        return 2 + (nch * sw) / 8 + chk;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
//==============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with combinational read of the head entry.
// Revision : 1.0 - initial release
//==============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int C_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [C_AW:0]    wr_ptr_q;
    logic [C_AW:0]    wr_ptr_d;
    logic [C_AW:0]    rd_ptr_q;
    logic [C_AW:0]    rd_ptr_d;
    logic             w_wr;
    logic             w_rd;

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign w_wr = push_i & (~full_o | pop_i);
    assign w_rd = pop_i & ~empty_o;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[C_AW] != rd_ptr_q[C_AW]) &&
                     (wr_ptr_q[C_AW-1:0] == rd_ptr_q[C_AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[C_AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_wr) wr_ptr_d = wr_ptr_q + (C_AW+1)'(1);
        if (w_rd) rd_ptr_d = rd_ptr_q + (C_AW+1)'(1);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr) mem_q[wr_ptr_q[C_AW-1:0]] <= wdata_i;
    end

endmodule
`default_nettype wire

// File: rtl/sample_frame_tx.sv
`default_nettype none
//==============================================================================
// Module   : sample_frame_tx
// Brief    : Buffers multi-channel samples and emits them to a UART as
//            sync/seq/data/checksum frames with sticky overflow reporting.
// Revision : 1.0 - initial release
//==============================================================================
module sample_frame_tx
    import sample_frame_pkg::*;
#(
    parameter int         P_NCH    = 3,
    parameter int         P_SW     = 16,
    parameter int         P_DEPTH  = 4,
    parameter logic [7:0] P_SYNC   = C_SYNC_DEFAULT,
    parameter int         P_CHKSUM = 1
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic [P_NCH*P_SW-1:0]  sample_i,
    input  logic                   sample_valid_i,
    output logic [7:0]             tx_byte_o,
    output logic                   tx_start_o,
    input  logic                   tx_done_tick_i,
    output logic                   busy_o,
    output logic                   overflow_o,
    input  logic                   ovf_clr_i
);

    localparam int C_DW    = P_NCH * P_SW;
    localparam int C_FW    = C_DW + 8;
    localparam int C_NDB   = nb(P_NCH, P_SW, P_CHKSUM) - 2 - P_CHKSUM;
    localparam int C_CNT_W = (C_NDB > 1) ? $clog2(C_NDB) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(C_NDB - 1);

    state_e                   state_q;
    state_e                   state_d;
    logic [7:0]               seq_q;
    logic [7:0]               seq_d;
    logic                     ovf_q;
    logic                     ovf_d;
    logic [7:0]               byte_q;
    logic [7:0]               byte_d;
    logic                     start_q;
    logic                     start_d;
    logic [7:0]               chk_q;
    logic [7:0]               chk_d;
    logic [C_DW-1:0]          shreg_q;
    logic [C_DW-1:0]          shreg_d;
    logic [7:0]               fseq_q;
    logic [7:0]               fseq_d;
    logic [C_CNT_W-1:0]       cnt_q;
    logic [C_CNT_W-1:0]       cnt_d;

    logic                     w_push;
    logic                     w_pop;
    logic                     w_drop;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic [$clog2(P_DEPTH):0] w_fifo_count;
    logic [C_FW-1:0]          w_fifo_rdata;
    logic                     w_tick;
    logic                     w_last;
    logic [7:0]               w_top;

    sync_fifo #(
        .WIDTH (C_FW),
        .DEPTH (P_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .wdata_i ({seq_q, sample_i}),
        .rdata_o (w_fifo_rdata),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

    assign w_push = sample_valid_i & (~w_fifo_full | w_pop);
    assign w_drop = sample_valid_i & ~w_push;

    // The UART tick only counts once the start pulse for the current byte is gone.
    assign w_tick = tx_done_tick_i & ~start_q & (state_q != ST_IDLE);
    assign w_last = (cnt_q == C_CNT_LAST);
    assign w_top  = shreg_q[C_DW-1 -: 8];

    always_comb begin
        seq_d = seq_q + {7'd0, sample_valid_i};
        ovf_d = w_drop | (ovf_q & ~ovf_clr_i);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!w_fifo_empty) state_d = ST_SYNC;
            ST_SYNC: if (w_tick) state_d = ST_SEQ;
            ST_SEQ:  if (w_tick) state_d = ST_DATA;
            ST_DATA: if (w_tick && w_last) state_d = (P_CHKSUM != 0) ? ST_CHK : ST_IDLE;
            ST_CHK:  if (w_tick) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start_d = 1'b0;
        byte_d  = byte_q;
        chk_d   = chk_q;
        shreg_d = shreg_q;
        fseq_d  = fseq_q;
        cnt_d   = cnt_q;
        w_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop   = 1'b1;
                    shreg_d = w_fifo_rdata[C_DW-1:0];
                    fseq_d  = w_fifo_rdata[C_FW-1:C_DW];
                    chk_d   = 8'd0;
                    byte_d  = P_SYNC;
                    start_d = 1'b1;
                end
            end
            ST_SYNC: begin
                if (w_tick) begin
                    byte_d  = fseq_q;
                    chk_d   = chk_q + fseq_q;
                    start_d = 1'b1;
                end
            end
            ST_SEQ: begin
                if (w_tick) begin
                    byte_d  = w_top;
                    chk_d   = chk_q + w_top;
                    shreg_d = shreg_q << 8;
                    cnt_d   = '0;
                    start_d = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (!w_last) begin
                        byte_d  = w_top;
                        chk_d   = chk_q + w_top;
                        shreg_d = shreg_q << 8;
                        cnt_d   = cnt_q + C_CNT_W'(1);
                        start_d = 1'b1;
                    end else if (P_CHKSUM != 0) begin
                        // Negated running sum makes seq + data + chk == 0 mod 256.
                        byte_d  = 8'd0 - chk_q;
                        start_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            seq_q   <= 8'd0;
            ovf_q   <= 1'b0;
            byte_q  <= 8'd0;
            start_q <= 1'b0;
            chk_q   <= 8'd0;
            shreg_q <= '0;
            fseq_q  <= 8'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            ovf_q   <= ovf_d;
            byte_q  <= byte_d;
            start_q <= start_d;
            chk_q   <= chk_d;
            shreg_q <= shreg_d;
            fseq_q  <= fseq_d;
            cnt_q   <= cnt_d;
        end
    end

    assign tx_byte_o  = byte_q;
    assign tx_start_o = start_q;
    assign overflow_o = ovf_q;
    assign busy_o     = (state_q != ST_IDLE) | (w_fifo_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_sample_frame_tx.sv
`default_nettype none
//==============================================================================
// Module   : tb_sample_frame_tx
// Brief    : Directed self-checking bench for sample_frame_tx (two configs).
// Revision : 1.0 - initial release
//==============================================================================
module tb_sample_frame_tx;

    logic        clk = 1'b0;
    logic        rstn;
    logic [47:0] s0;
    logic        v0, tick0, clr0;
    logic [7:0]  b0;
    logic        st0, busy0, ovf0;
    logic [7:0]  s1;
    logic        v1, tick1, clr1;
    logic [7:0]  b1;
    logic        st1, busy1, ovf1;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] small_exp [3];
    logic [7:0] ovf_chk   [5];
    logic [7:0] sim_chk   [5];

    always #5 clk = ~clk;

    sample_frame_tx #(
        .P_NCH(3), .P_SW(16), .P_DEPTH(4), .P_SYNC(8'hA5), .P_CHKSUM(1)
    ) u_dut0 (
        .clk_i(clk), .rstn_i(rstn), .sample_i(s0), .sample_valid_i(v0),
        .tx_byte_o(b0), .tx_start_o(st0), .tx_done_tick_i(tick0),
        .busy_o(busy0), .overflow_o(ovf0), .ovf_clr_i(clr0)
    );

    sample_frame_tx #(
        .P_NCH(1), .P_SW(8), .P_DEPTH(4), .P_SYNC(8'hA5), .P_CHKSUM(0)
    ) u_dut1 (
        .clk_i(clk), .rstn_i(rstn), .sample_i(s1), .sample_valid_i(v1),
        .tx_byte_o(b1), .tx_start_o(st1), .tx_done_tick_i(tick1),
        .busy_o(busy1), .overflow_o(ovf1), .ovf_clr_i(clr1)
    );

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wait_start0(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (st0 === 1'b1) break;
            cyc();
        end
        check1(tag, st0, 1'b1);
    endtask

    // Acts as the UART for one byte; early=1 also ticks during the start cycle.
    task automatic uart_byte(input string tag, input logic [7:0] exp,
                             input bit early, input bit skip_start);
        if (!skip_start) check1({tag, "_start"}, st0, 1'b1);
        check8({tag, "_byte"}, b0, exp);
        if (early) begin
            tick0 = 1'b1;
            cyc();
            tick0 = 1'b0;
        end else begin
            cyc();
        end
        check1({tag, "_nostart"}, st0, 1'b0);
        check8({tag, "_stable"}, b0, exp);
        tick0 = 1'b1;
        cyc();
        tick0 = 1'b0;
    endtask

    task automatic recv_frame0(input string tag, input logic [7:0] seq,
                               input logic [47:0] data, input logic [7:0] chk,
                               input bit skip_start);
        logic [7:0] exp [9];
        exp[0] = 8'hA5;
        exp[1] = seq;
        for (int j = 0; j < 6; j++) exp[2+j] = data[47-8*j -: 8];
        exp[8] = chk;
        if (!skip_start) wait_start0({tag, "_sync"});
        for (int i = 0; i < 9; i++)
            uart_byte($sformatf("%s_b%0d", tag, i), exp[i], i == 1, skip_start && i == 0);
        check1({tag, "_end"}, st0, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        small_exp = '{8'hA5, 8'h00, 8'h7F};
        ovf_chk   = '{8'h00, 8'hFE, 8'hFC, 8'hFA, 8'hF8};
        sim_chk   = '{8'hF0, 8'hEE, 8'hEC, 8'hEA, 8'hE8};
        rstn = 1'b0;
        s0 = '0; v0 = 1'b0; tick0 = 1'b0; clr0 = 1'b0;
        s1 = '0; v1 = 1'b0; tick1 = 1'b0; clr1 = 1'b0;
        cyc();
        cyc();
        check8("rst_byte0", b0, 8'h00);
        check1("rst_start0", st0, 1'b0);
        check1("rst_busy0", busy0, 1'b0);
        check1("rst_ovf0", ovf0, 1'b0);
        check8("rst_byte1", b1, 8'h00);
        check1("rst_ovf1", ovf1, 1'b0);
        rstn = 1'b1;
        cyc();

        // Basic frame with two-cycle latency
        s0 = 48'h010203040506; v0 = 1'b1;
        cyc();
        v0 = 1'b0;
        check1("lat_n1_start", st0, 1'b0);
        check1("lat_n1_busy", busy0, 1'b1);
        cyc();
        check1("lat_n2_start", st0, 1'b1);
        check8("lat_n2_byte", b0, 8'hA5);
        recv_frame0("basic", 8'h00, 48'h010203040506, 8'hEB, 1'b0);
        check1("basic_busy_done", busy0, 1'b0);

        // Single 8-bit channel, no checksum
        s1 = 8'h7F; v1 = 1'b1;
        cyc();
        v1 = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            check1($sformatf("small_start%0d", i), st1, 1'b1);
            check8($sformatf("small_byte%0d", i), b1, small_exp[i]);
            cyc();
            tick1 = 1'b1;
            cyc();
            tick1 = 1'b0;
        end
        check1("small_idle", st1, 1'b0);
        check1("small_busy", busy1, 1'b0);

        // Reset during the wait on the second data byte
        s0 = 48'h111122223333; v0 = 1'b1;
        cyc();
        v0 = 1'b0;
        wait_start0("rmf_sync");
        uart_byte("rmf_b0", 8'hA5, 1'b0, 1'b0);
        uart_byte("rmf_b1", 8'h01, 1'b0, 1'b0);
        uart_byte("rmf_b2", 8'h11, 1'b0, 1'b0);
        check1("rmf_d2_start", st0, 1'b1);
        check8("rmf_d2_byte", b0, 8'h11);
        cyc();
        rstn = 1'b0;
        #1;
        check8("rmf_rst_byte", b0, 8'h00);
        check1("rmf_rst_start", st0, 1'b0);
        check1("rmf_rst_busy", busy0, 1'b0);
        check1("rmf_rst_ovf", ovf0, 1'b0);
        cyc();
        cyc();
        check1("rmf_no_pulse", st0, 1'b0);
        rstn = 1'b1;
        tick0 = 1'b1;
        cyc();
        tick0 = 1'b0;
        check1("rmf_stray_tick", st0, 1'b0);
        cyc();
        check1("rmf_stray_tick2", st0, 1'b0);
        check1("rmf_idle_busy", busy0, 1'b0);

        // Overflow: six strobes with the UART stalled
        for (int k = 0; k < 6; k++) begin
            s0 = 48'(k); v0 = 1'b1;
            cyc();
            v0 = 1'b0;
            cyc();
            cyc();
            if (k == 4) check1("ovf_before6", ovf0, 1'b0);
        end
        check1("ovf_after6", ovf0, 1'b1);
        check8("ovf_stall_byte", b0, 8'hA5);
        check1("ovf_stall_busy", busy0, 1'b1);
        recv_frame0("ovf_f0", 8'h00, 48'h0, ovf_chk[0], 1'b1);
        for (int k = 1; k < 5; k++) begin
            cyc();
            check1($sformatf("ovf_b2b%0d", k), st0, 1'b1);
            recv_frame0($sformatf("ovf_f%0d", k), 8'(k), 48'(k), ovf_chk[k], 1'b0);
        end
        check1("ovf_drained", busy0, 1'b0);
        s0 = 48'h6; v0 = 1'b1;
        cyc();
        v0 = 1'b0;
        recv_frame0("ovf_f6", 8'h06, 48'h6, 8'hF4, 1'b0);
        check1("ovf_still_set", ovf0, 1'b1);
        clr0 = 1'b1;
        cyc();
        clr0 = 1'b0;
        check1("ovf_cleared", ovf0, 1'b0);

        // Strobe into a full FIFO in the cycle the head is popped
        for (int k = 0; k < 5; k++) begin
            s0 = 48'(7 + k); v0 = 1'b1;
            cyc();
        end
        v0 = 1'b0;
        check1("sim_fill_ovf", ovf0, 1'b0);
        check8("sim_hold_byte", b0, 8'hA5);
        recv_frame0("sim_f7", 8'h07, 48'h7, 8'hF2, 1'b1);
        s0 = 48'hC; v0 = 1'b1;
        cyc();
        v0 = 1'b0;
        check1("sim_pop_push_ovf", ovf0, 1'b0);
        check1("sim_b2b", st0, 1'b1);
        for (int k = 0; k < 5; k++)
            recv_frame0($sformatf("sim_f%0d", 8 + k), 8'(8 + k), 48'(8 + k), sim_chk[k], 1'b0);
        check1("sim_drained", busy0, 1'b0);

        // Sequence wrap over 257 accepted strobes
        rstn = 1'b0;
        cyc();
        rstn = 1'b1;
        cyc();
        for (int k = 0; k < 257; k++) begin
            s0 = 48'h0; v0 = 1'b1;
            cyc();
            v0 = 1'b0;
            recv_frame0($sformatf("wrap%0d", k), 8'(k), 48'h0, 8'(-k), 1'b0);
        end

        // Clear coinciding with a drop: the drop wins
        for (int k = 0; k < 6; k++) begin
            s0 = 48'(k); v0 = 1'b1;
            clr0 = (k == 5);
            cyc();
            v0 = 1'b0;
            clr0 = 1'b0;
            cyc();
            cyc();
            if (k == 4) check1("clr_drop_before", ovf0, 1'b0);
        end
        check1("clr_drop_set_wins", ovf0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
